// File: rtl/multicycle_ctrl_if.sv
// Control bus between multicycle_ctrl (master) and the RISC-DCCCLXVII datapath (slave).
// Carries the IR/flag/ready inputs, all control strobes and the trap/debug status.
interface multicycle_ctrl_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic [31:0]        instruction;
  logic               alu_zero;
  logic               imem_ready;
  logic               dmem_ready;

  logic               PCWrite;
  logic               PCSource;
  logic               PCWriteCond;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic               LoadAOut;
  logic               RegWrite;
  logic               LoadRegA;
  logic               LoadRegB;
  logic               MemToReg;
  logic               DMemOp;
  logic               DMemReq;
  logic               LoadMDR;
  logic               IMemRead;
  logic               IRWrite;

  logic               trap;
  logic [1:0]         trap_cause;
  logic [3:0]         state_out;

  modport master (
    input  instruction, alu_zero, imem_ready, dmem_ready,
    output PCWrite, PCSource, PCWriteCond, ALUSrcA, ALUSrcB, ALUOp, LoadAOut,
           RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp, DMemReq, LoadMDR,
           IMemRead, IRWrite, trap, trap_cause, state_out
  );

  modport slave (
    output instruction, alu_zero, imem_ready, dmem_ready,
    input  PCWrite, PCSource, PCWriteCond, ALUSrcA, ALUSrcB, ALUOp, LoadAOut,
           RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp, DMemReq, LoadMDR,
           IMemRead, IRWrite, trap, trap_cause, state_out
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RISC-DCCCLXVII datapath with sticky trap state.
// Define CTRL_MEM_HANDSHAKE_EN to honour imem/dmem ready with a WAIT_MAX timeout.
module multicycle_ctrl #(
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic           clk,
  input logic           reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    START    = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    EXEC_R   = 4'd4,
    EXEC_I   = 4'd5,
    ALU_WB   = 4'd6,
    BRANCH   = 4'd7,
    MEM_LD   = 4'd8,
    MEM_SD   = 4'd9,
    LD_WB    = 4'd10,
    TRAP     = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    ALU_LOAD = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_INC  = 3'd6
  } aluop_e;

  typedef struct packed {
    logic       pcWrite;
    logic       pcSource;
    logic       pcWriteCond;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    aluop_e     aluOp;
    logic       loadAOut;
    logic       regWrite;
    logic       loadRegA;
    logic       loadRegB;
    logic       memToReg;
    logic       dMemOp;
    logic       dMemReq;
    logic       loadMdr;
    logic       iMemRead;
    logic       irWrite;
  } ctl_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100111;

  state_e     state, nextState;
  logic [1:0] trapCause, causeNext;
  ctl_t       ctl;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  aluop_e     rOp;
  logic       rLegal, opLegal, functLegal;
  logic       iRdy, dRdy, waitExpired;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign funct7 = bus.instruction[31:25];

  always_comb begin
    rOp    = ALU_ADD;
    rLegal = 1'b1;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: rOp = ALU_ADD;
      {7'b0100000, 3'b000}: rOp = ALU_SUB;
      {7'b0000000, 3'b111}: rOp = ALU_AND;
      {7'b0000000, 3'b100}: rOp = ALU_XOR;
      default:              rLegal = 1'b0;
    endcase
  end

  always_comb begin
    opLegal    = 1'b1;
    functLegal = 1'b1;
    case (opcode)
      OP_R:         functLegal = rLegal;
      OP_ADDI:      functLegal = (funct3 == 3'b000);
      OP_BR:        functLegal = (funct3[2:1] == 2'b00);
      OP_LD, OP_SD: functLegal = 1'b1;
      default:      opLegal    = 1'b0;
    endcase
  end

`ifdef CTRL_MEM_HANDSHAKE_EN
  localparam int unsigned CW   = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

  logic [CW-1:0] waitCnt;
  logic          waiting;

  assign iRdy        = bus.imem_ready;
  assign dRdy        = bus.dmem_ready;
  assign waitExpired = (waitCnt == WMAX);
  assign waiting     = ((state == FETCH) && !iRdy) ||
                       (((state == MEM_LD) || (state == MEM_SD)) && !dRdy);

  // Any state change (including the timeout into TRAP) restarts the count.
  always_ff @(posedge clk) begin
    if (reset)                   waitCnt <= '0;
    else if (nextState != state) waitCnt <= '0;
    else if (waiting)            waitCnt <= waitCnt + CW'(1);
  end
`else
  assign iRdy        = 1'b1;
  assign dRdy        = 1'b1;
  assign waitExpired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= START;
      trapCause <= '0;
    end else begin
      state     <= nextState;
      trapCause <= causeNext;
    end
  end

  always_comb begin
    nextState = state;
    causeNext = trapCause;
    ctl       = '0;
    case (state)
      START: nextState = FETCH;
      FETCH: begin
        ctl.iMemRead = 1'b1;
        ctl.aluSrcB  = 2'b01;
        ctl.aluOp    = ALU_ADD;
        // Ready takes priority over a saturated wait counter.
        if (iRdy) begin
          ctl.pcWrite = 1'b1;
          ctl.irWrite = 1'b1;
          nextState   = DECODE;
        end else if (waitExpired) begin
          nextState = TRAP;
          causeNext = 2'b11;
        end
      end
      DECODE: begin
        ctl.loadRegA = 1'b1;
        ctl.loadRegB = 1'b1;
        ctl.loadAOut = 1'b1;
        ctl.aluSrcB  = 2'b11;
        ctl.aluOp    = ALU_ADD;
        if (!opLegal) begin
          nextState = TRAP;
          causeNext = 2'b01;
        end else if (!functLegal) begin
          nextState = TRAP;
          causeNext = 2'b10;
        end else begin
          case (opcode)
            OP_LD, OP_SD: nextState = MEM_ADDR;
            OP_R:         nextState = EXEC_R;
            OP_ADDI:      nextState = EXEC_I;
            default:      nextState = BRANCH;
          endcase
        end
      end
      MEM_ADDR: begin
        ctl.loadAOut = 1'b1;
        ctl.aluSrcA  = 1'b1;
        ctl.aluSrcB  = 2'b10;
        ctl.aluOp    = ALU_ADD;
        nextState    = (opcode == OP_LD) ? MEM_LD : MEM_SD;
      end
      EXEC_R: begin
        ctl.loadAOut = 1'b1;
        ctl.aluSrcA  = 1'b1;
        ctl.aluOp    = rOp;
        nextState    = ALU_WB;
      end
      EXEC_I: begin
        ctl.loadAOut = 1'b1;
        ctl.aluSrcA  = 1'b1;
        ctl.aluSrcB  = 2'b10;
        ctl.aluOp    = ALU_ADD;
        nextState    = ALU_WB;
      end
      ALU_WB: begin
        ctl.regWrite = 1'b1;
        nextState    = FETCH;
      end
      BRANCH: begin
        // funct3[0] selects bne, inverting the sense of the zero flag.
        ctl.aluSrcA     = 1'b1;
        ctl.aluOp       = ALU_SUB;
        ctl.pcSource    = 1'b1;
        ctl.pcWriteCond = bus.alu_zero ^ funct3[0];
        nextState       = FETCH;
      end
      MEM_LD: begin
        ctl.dMemReq = 1'b1;
        if (dRdy) begin
          ctl.loadMdr = 1'b1;
          nextState   = LD_WB;
        end else if (waitExpired) begin
          nextState = TRAP;
          causeNext = 2'b11;
        end
      end
      MEM_SD: begin
        ctl.dMemReq = 1'b1;
        ctl.dMemOp  = 1'b1;
        if (dRdy) begin
          nextState = FETCH;
        end else if (waitExpired) begin
          nextState = TRAP;
          causeNext = 2'b11;
        end
      end
      LD_WB: begin
        ctl.regWrite = 1'b1;
        ctl.memToReg = 1'b1;
        nextState    = FETCH;
      end
      TRAP:    nextState = TRAP;
      default: nextState = START;
    endcase
    if (reset) ctl = '0;
  end

  assign bus.PCWrite     = ctl.pcWrite;
  assign bus.PCSource    = ctl.pcSource;
  assign bus.PCWriteCond = ctl.pcWriteCond;
  assign bus.ALUSrcA     = ctl.aluSrcA;
  assign bus.ALUSrcB     = ctl.aluSrcB;
  assign bus.ALUOp       = ALUOP_W'(ctl.aluOp);
  assign bus.LoadAOut    = ctl.loadAOut;
  assign bus.RegWrite    = ctl.regWrite;
  assign bus.LoadRegA    = ctl.loadRegA;
  assign bus.LoadRegB    = ctl.loadRegB;
  assign bus.MemToReg    = ctl.memToReg;
  assign bus.DMemOp      = ctl.dMemOp;
  assign bus.DMemReq     = ctl.dMemReq;
  assign bus.LoadMDR     = ctl.loadMdr;
  assign bus.IMemRead    = ctl.iMemRead;
  assign bus.IRWrite     = ctl.irWrite;
  assign bus.trap        = (state == TRAP);
  assign bus.trap_cause  = trapCause;
  assign bus.state_out   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instructions,
// with expected per-cycle behaviour built from instruction-level phase lists.
module tb_multicycle_ctrl;

  localparam int unsigned WMAX = 15;
`ifdef CTRL_MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100111;

  typedef struct packed {
    logic       pcWrite;
    logic       pcSource;
    logic       pcWriteCond;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic       loadAOut;
    logic       regWrite;
    logic       loadRegA;
    logic       loadRegB;
    logic       memToReg;
    logic       dMemOp;
    logic       dMemReq;
    logic       loadMdr;
    logic       iMemRead;
    logic       irWrite;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       imr;
    logic       dmr;
    ctl_t       ctl;
    logic       trap;
    logic [1:0] cause;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  multicycle_ctrl_if #(.ALUOP_W(4)) bus ();

  multicycle_ctrl #(.ALUOP_W(4), .WAIT_MAX(WMAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned nChecks = 0;
  int unsigned nErrors = 0;
  cyc_t        expQ[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic ctl_t obs();
    ctl_t o;
    o.pcWrite     = bus.PCWrite;
    o.pcSource    = bus.PCSource;
    o.pcWriteCond = bus.PCWriteCond;
    o.aluSrcA     = bus.ALUSrcA;
    o.aluSrcB     = bus.ALUSrcB;
    o.aluOp       = bus.ALUOp;
    o.loadAOut    = bus.LoadAOut;
    o.regWrite    = bus.RegWrite;
    o.loadRegA    = bus.LoadRegA;
    o.loadRegB    = bus.LoadRegB;
    o.memToReg    = bus.MemToReg;
    o.dMemOp      = bus.DMemOp;
    o.dMemReq     = bus.DMemReq;
    o.loadMdr     = bus.LoadMDR;
    o.iMemRead    = bus.IMemRead;
    o.irWrite     = bus.IRWrite;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic push(input logic [3:0] st, input logic imr, input logic dmr, input ctl_t c,
                      input logic tr, input logic [1:0] cs);
    cyc_t e;
    e.st = st; e.imr = imr; e.dmr = dmr; e.ctl = c; e.trap = tr; e.cause = cs;
    expQ.push_back(e);
  endtask

  // Fetch phase: 'waits' not-ready cycles, then the ready cycle or a timeout.
  task automatic pushFetch(input int unsigned waits, output bit trapped);
    ctl_t c;
    ctl_t r;
    int unsigned n;
    c = '0; c.iMemRead = 1'b1; c.aluSrcB = 2'd1; c.aluOp = 4'd1;
    r = c;  r.pcWrite = 1'b1;  r.irWrite = 1'b1;
    trapped = 1'b0;
    if (!HS) begin
      push(4'd1, rnd(), rnd(), r, 1'b0, 2'd0);
      return;
    end
    n = (waits > WMAX) ? WMAX + 1 : waits;
    for (int unsigned i = 0; i < n; i++) push(4'd1, 1'b0, rnd(), c, 1'b0, 2'd0);
    if (waits > WMAX) begin
      trapped = 1'b1;
      return;
    end
    push(4'd1, 1'b1, rnd(), r, 1'b0, 2'd0);
  endtask

  task automatic pushMem(input bit isLd, input int unsigned waits, output bit trapped);
    ctl_t c;
    ctl_t r;
    int unsigned n;
    logic [3:0] st;
    st = isLd ? 4'd8 : 4'd9;
    c = '0; c.dMemReq = 1'b1; c.dMemOp = !isLd;
    r = c;  r.loadMdr = isLd;
    trapped = 1'b0;
    if (!HS) begin
      push(st, rnd(), rnd(), r, 1'b0, 2'd0);
      return;
    end
    n = (waits > WMAX) ? WMAX + 1 : waits;
    for (int unsigned i = 0; i < n; i++) push(st, rnd(), 1'b0, c, 1'b0, 2'd0);
    if (waits > WMAX) begin
      trapped = 1'b1;
      return;
    end
    push(st, rnd(), 1'b1, r, 1'b0, 2'd0);
  endtask

  function automatic ctl_t ctlDecode();
    ctl_t c;
    c = '0; c.loadRegA = 1'b1; c.loadRegB = 1'b1; c.loadAOut = 1'b1;
    c.aluSrcB = 2'd3; c.aluOp = 4'd1;
    return c;
  endfunction

  function automatic ctl_t ctlMemAddr();
    ctl_t c;
    c = '0; c.loadAOut = 1'b1; c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluOp = 4'd1;
    return c;
  endfunction

  task automatic playQueue(input int unsigned maxN);
    cyc_t e;
    for (int unsigned i = 0; i < maxN && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      bus.imem_ready = e.imr;
      bus.dmem_ready = e.dmr;
      #1;
      check("state", 32'(bus.state_out), 32'(e.st));
      check("ctl", 32'(obs()), 32'(e.ctl));
      check("trap", 32'(bus.trap), 32'(e.trap));
      check("trap_cause", 32'(bus.trap_cause), 32'(e.cause));
      @(posedge clk);
      #1;
    end
    expQ.delete();
  endtask

  task automatic doReset(input bit chkSt, input logic [3:0] st);
    reset = 1'b1;
    bus.imem_ready = rnd();
    bus.dmem_ready = rnd();
    bus.alu_zero   = rnd();
    #1;
    if (chkSt) check("rstState", 32'(bus.state_out), 32'(st));
    check("rstCtl", 32'(obs()), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(4'd0, rnd(), rnd(), '0, 1'b0, 2'd0);
    playQueue(1);
  endtask

  // Instruction-level reference: derive phase list from mnemonic rules, then replay.
  task automatic runInstr(input logic [31:0] ins, input int unsigned fw, input int unsigned mw,
                          input logic az, input int unsigned hold);
    bit         tr;
    logic [1:0] cause;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] aluc;
    ctl_t       c;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    cause = 2'd0;
    aluc  = 4'd1;
    pushFetch(fw, tr);
    if (tr) cause = 2'd3;
    if (!tr) begin
      push(4'd2, rnd(), rnd(), ctlDecode(), 1'b0, 2'd0);
      if (opc == OP_R) begin
        if      (f7 == 7'h00 && f3 == 3'd0) aluc = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd0) aluc = 4'd2;
        else if (f7 == 7'h00 && f3 == 3'd7) aluc = 4'd3;
        else if (f7 == 7'h00 && f3 == 3'd4) aluc = 4'd4;
        else cause = 2'd2;
      end else if (opc == OP_ADDI) begin
        if (f3 != 3'd0) cause = 2'd2;
      end else if (opc == OP_BR) begin
        if (f3 > 3'd1) cause = 2'd2;
      end else if (opc != OP_LD && opc != OP_SD) begin
        cause = 2'd1;
      end
      tr = (cause != 2'd0);
      if (!tr) begin
        if (opc == OP_R || opc == OP_ADDI) begin
          c = '0; c.loadAOut = 1'b1; c.aluSrcA = 1'b1;
          c.aluSrcB = (opc == OP_R) ? 2'd0 : 2'd2;
          c.aluOp   = aluc;
          push((opc == OP_R) ? 4'd4 : 4'd5, rnd(), rnd(), c, 1'b0, 2'd0);
          c = '0; c.regWrite = 1'b1;
          push(4'd6, rnd(), rnd(), c, 1'b0, 2'd0);
        end else if (opc == OP_BR) begin
          c = '0; c.aluSrcA = 1'b1; c.aluOp = 4'd2; c.pcSource = 1'b1;
          c.pcWriteCond = az ^ f3[0];
          push(4'd7, rnd(), rnd(), c, 1'b0, 2'd0);
        end else begin
          push(4'd3, rnd(), rnd(), ctlMemAddr(), 1'b0, 2'd0);
          pushMem(opc == OP_LD, mw, tr);
          if (tr) cause = 2'd3;
          else if (opc == OP_LD) begin
            c = '0; c.regWrite = 1'b1; c.memToReg = 1'b1;
            push(4'd10, rnd(), rnd(), c, 1'b0, 2'd0);
          end
        end
      end
    end
    if (tr) for (int unsigned i = 0; i < hold; i++) push(4'd15, rnd(), rnd(), '0, 1'b1, cause);
    bus.instruction = ins;
    bus.alu_zero    = az;
    playQueue(expQ.size());
    if (tr) doReset(1'b1, 4'd15);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 10'($urandom), f3, 5'($urandom), opc};
  endfunction

  function automatic int unsigned pickWait();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 18) return $urandom_range(1, 3);
    if (r == 18) return WMAX;
    return WMAX + 1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          trd;
    logic [31:0] ins;
    logic [6:0]  opc;
    int unsigned kind;
    bus.instruction = '0;
    bus.alu_zero    = 1'b0;
    bus.imem_ready  = 1'b1;
    bus.dmem_ready  = 1'b1;
    doReset(1'b0, 4'd0);
    doReset(1'b1, 4'd1);

    runInstr(32'h002081B3, 0, 0, 1'b0, 0);
    runInstr(32'h402081B3, 0, 0, 1'b0, 0);
    runInstr(mk(7'h00, 3'd4, OP_R), 0, 0, 1'b0, 0);
    runInstr(mk(7'h00, 3'd7, OP_R), 0, 0, 1'b1, 0);
    runInstr(mk(7'h20, 3'd7, OP_R), 0, 0, 1'b0, 20);
    runInstr(mk(7'($urandom), 3'd0, OP_ADDI), 0, 0, 1'b0, 0);
    runInstr(mk(7'($urandom), 3'd0, OP_BR), 0, 0, 1'b1, 0);
    runInstr(mk(7'($urandom), 3'd1, OP_BR), 0, 0, 1'b1, 0);
    runInstr(mk(7'($urandom), 3'd1, OP_BR), 0, 0, 1'b0, 0);
    runInstr(mk(7'($urandom), 3'd2, OP_LD), 0, 3, 1'b0, 0);
    runInstr(32'h002081B3, WMAX, 0, 1'b0, 0);
    runInstr(32'h002081B3, WMAX + 1, 0, 1'b0, 5);
    runInstr(mk(7'($urandom), 3'd3, OP_SD), 0, WMAX, 1'b0, 0);
    runInstr(mk(7'($urandom), 3'd3, OP_LD), 0, WMAX + 1, 1'b0, 4);
    runInstr({25'($urandom), 7'h7F}, 0, 0, 1'b0, 5);

    // Reset asserted while a store is waiting on the data memory.
    pushFetch(0, trd);
    push(4'd2, rnd(), rnd(), ctlDecode(), 1'b0, 2'd0);
    push(4'd3, rnd(), rnd(), ctlMemAddr(), 1'b0, 2'd0);
    pushMem(1'b0, 3, trd);
    bus.instruction = mk(7'($urandom), 3'd3, OP_SD);
    playQueue(4);
    doReset(1'b1, HS ? 4'd9 : 4'd1);
    runInstr(32'h002081B3, 0, 0, 1'b0, 0);

    for (int unsigned n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 11);
      case (kind)
        0:  ins = mk(7'h00, 3'd0, OP_R);
        1:  ins = mk(7'h20, 3'd0, OP_R);
        2:  ins = mk(7'h00, 3'd7, OP_R);
        3:  ins = mk(7'h00, 3'd4, OP_R);
        4:  ins = mk(7'($urandom), 3'd0, OP_ADDI);
        5:  ins = mk(7'($urandom), 3'($urandom), OP_LD);
        6:  ins = mk(7'($urandom), 3'($urandom), OP_SD);
        7:  ins = mk(7'($urandom), 3'd0, OP_BR);
        8:  ins = mk(7'($urandom), 3'd1, OP_BR);
        9:  ins = mk(7'($urandom), 3'($urandom), OP_R);
        10: ins = mk(7'($urandom), 3'($urandom), rnd() ? OP_ADDI : OP_BR);
        default: begin
          opc = 7'($urandom);
          ins = mk(7'($urandom), 3'($urandom), opc);
        end
      endcase
      runInstr(ins, pickWait(), pickWait(), rnd(), 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
